// File: rtl/hms_cmd_sequencer.sv
// rtl/hms_cmd_sequencer.sv - expands load/nudge commands into hh:mm:ss timekeeper strobe sequences
module hms_cmd_sequencer #(
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [4:0] cmd_hrs,
  input  logic [5:0] cmd_min,
  input  logic [5:0] cmd_sec,
  input  logic [1:0] cmd_field,
  input  logic       cmd_dir,
  input  logic [5:0] cmd_cnt,
  output logic       ss,
  output logic       sel,
  output logic       inc,
  output logic       dec,
  output logic       load,
  output logic [1:0] addr,
  output logic [5:0] din,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE, S_ENTER, S_LD_H, S_LD_M, S_LD_S, S_NAV, S_STEP, S_EXIT, S_DONE, S_WAIT
  } state_t;

  state_t     state, state_d, ret_q, ret_d, follow;
  logic [5:0] rem_q, rem_d;
  logic [4:0] gap_q, gap_d;
  logic       strobe_st;

  logic       op_q, dir_q;
  logic [4:0] hrs_q;
  logic [5:0] min_q, sec_q, cnt_q;
  logic [1:0] field_q;

  logic       accept, cmd_ok;
  logic       ss_d, sel_d, inc_d, dec_d, load_d, busy_d, done_d, err_d, ready_d;
  logic [1:0] addr_d;
  logic [5:0] din_d;

  assign accept = cmd_valid && cmd_ready;
  assign cmd_ok = cmd_op ? ((cmd_field != 2'd0) && (cmd_cnt != 6'd0))
                         : ((cmd_hrs <= 5'd23) && (cmd_min <= 6'd59) && (cmd_sec <= 6'd59));

  // Next-state, pulse counting and registered-output precompute
  always_comb begin
    state_d   = state;
    ret_d     = ret_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    follow    = S_IDLE;
    strobe_st = 1'b0;
    err_d     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_ok) state_d = S_ENTER;
          else        err_d   = 1'b1;
        end
      end
      S_ENTER: begin
        strobe_st = 1'b1;
        follow    = op_q ? S_NAV : S_LD_H;
        // hrs needs one sel, min two, sec three
        rem_d     = 6'd4 - {4'b0000, field_q};
      end
      S_LD_H: begin strobe_st = 1'b1; follow = S_LD_M; end
      S_LD_M: begin strobe_st = 1'b1; follow = S_LD_S; end
      S_LD_S: begin strobe_st = 1'b1; follow = S_EXIT; end
      S_NAV: begin
        strobe_st = 1'b1;
        if (rem_q == 6'd1) begin
          follow = S_STEP;
          rem_d  = cnt_q;
        end else begin
          follow = S_NAV;
          rem_d  = rem_q - 6'd1;
        end
      end
      S_STEP: begin
        strobe_st = 1'b1;
        rem_d     = rem_q - 6'd1;
        follow    = (rem_q == 6'd1) ? S_EXIT : S_STEP;
      end
      S_EXIT: begin strobe_st = 1'b1; follow = S_DONE; end
      S_DONE: state_d = S_IDLE;
      S_WAIT: begin
        if (gap_q <= 5'd1) state_d = ret_q;
        else               gap_d   = gap_q - 5'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // every strobe is followed by GAP idle cycles before the next one
    if (strobe_st) begin
      if (GAP == 0) begin
        state_d = follow;
      end else begin
        state_d = S_WAIT;
        ret_d   = follow;
        gap_d   = 5'(GAP);
      end
    end

    ss_d    = (state_d == S_ENTER) || (state_d == S_EXIT);
    sel_d   = (state_d == S_NAV);
    inc_d   = (state_d == S_STEP) && !dir_q;
    dec_d   = (state_d == S_STEP) && dir_q;
    load_d  = (state_d == S_LD_H) || (state_d == S_LD_M) || (state_d == S_LD_S);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
    addr_d  = 2'd0;
    din_d   = 6'd0;
    case (state_d)
      S_LD_H: begin addr_d = 2'd3; din_d = {1'b0, hrs_q}; end
      S_LD_M: begin addr_d = 2'd2; din_d = min_q; end
      S_LD_S: begin addr_d = 2'd1; din_d = sec_q; end
      default: ;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ret_q     <= S_IDLE;
      rem_q     <= 6'd0;
      gap_q     <= 5'd0;
      cmd_ready <= 1'b1;
      ss        <= 1'b0;
      sel       <= 1'b0;
      inc       <= 1'b0;
      dec       <= 1'b0;
      load      <= 1'b0;
      addr      <= 2'd0;
      din       <= 6'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      ret_q     <= ret_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      cmd_ready <= ready_d;
      ss        <= ss_d;
      sel       <= sel_d;
      inc       <= inc_d;
      dec       <= dec_d;
      load      <= load_d;
      addr      <= addr_d;
      din       <= din_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  // Command capture at the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= 1'b0;
      hrs_q   <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      field_q <= 2'd0;
      dir_q   <= 1'b0;
      cnt_q   <= 6'd0;
    end else if (accept) begin
      op_q    <= cmd_op;
      hrs_q   <= cmd_hrs;
      min_q   <= cmd_min;
      sec_q   <= cmd_sec;
      field_q <= cmd_field;
      dir_q   <= cmd_dir;
      cnt_q   <= cmd_cnt;
    end
  end

endmodule
